// File: rtl/MD_pkg.sv
// rtl/MD_pkg.sv - shared widths and neighbour-code type for the 3D neighbour-cell pipeline
//
// Purpose : common constants used by compute_nb_cid_3d_pipe and nb_code_1d.
// Contents: GLOBAL_CELL_ID_WIDTH, CELL_ID_WIDTH, NUM_CELL_FOLDS,
//           CELL_FOLD_ID_WIDTH, nb_code_t.
package MD_pkg;

    localparam int GLOBAL_CELL_ID_WIDTH = 4;
    localparam int CELL_ID_WIDTH        = 2;
    localparam int NUM_CELL_FOLDS       = 2;
    // One bit wider than strictly needed so an out-of-range fold id can be expressed.
    localparam int CELL_FOLD_ID_WIDTH   = 2;

    typedef enum logic [CELL_ID_WIDTH-1:0] {
        NB_NONE  = 2'b00,
        NB_MINUS = 2'b01,
        NB_HOME  = 2'b10,
        NB_PLUS  = 2'b11
    } nb_code_t;

endpackage

// File: rtl/nb_code_1d.sv
// rtl/nb_code_1d.sv - combinational per-dimension neighbour code
//
// Purpose: classify one source cell coordinate relative to a home coordinate
//          on a ring of gdim cells.
// Ports  : src  - source global cell id
//          home - home global cell id
//          gdim - number of cells along this dimension
//          code - NB_HOME / NB_PLUS / NB_MINUS / NB_NONE
module nb_code_1d
    import MD_pkg::*;
(
    input  logic [GLOBAL_CELL_ID_WIDTH-1:0] src,
    input  logic [GLOBAL_CELL_ID_WIDTH-1:0] home,
    input  logic [GLOBAL_CELL_ID_WIDTH-1:0] gdim,
    output nb_code_t                        code
);

    logic [GLOBAL_CELL_ID_WIDTH-1:0] plus_id;
    logic [GLOBAL_CELL_ID_WIDTH-1:0] minus_id;

    // Wrap is selected explicitly rather than by modulo so no intermediate
    // value ever exceeds gdim-1.
    always_comb begin
        plus_id  = (home == gdim - 1'b1) ? '0 : home + 1'b1;
        minus_id = (home == '0) ? gdim - 1'b1 : home - 1'b1;
    end

    // PLUS is tested before MINUS so that on a two-cell ring, where both
    // neighbours are the same cell, the result is NB_PLUS.
    always_comb begin
        code = NB_NONE;
        if (src >= gdim) begin
            code = NB_NONE;
        end else if (src == home) begin
            code = NB_HOME;
        end else if (src == plus_id) begin
            code = NB_PLUS;
        end else if (src == minus_id) begin
            code = NB_MINUS;
        end
    end

endmodule

// File: rtl/compute_nb_cid_3d_pipe.sv
// rtl/compute_nb_cid_3d_pipe.sv - two-stage pipeline producing 3D neighbour codes for a source cell
//
// Purpose: for each beat, look up the home cell of the selected fold and emit
//          per-dimension neighbour codes, a neighbour flag, a fold-range error
//          and the pass-through payload, with valid/ready flow control and
//          saturating neighbour / non-neighbour event counters.
// Ports  : clk, rst (async, active-high)
//          i_valid/o_ready, i_src_gcid_x/y/z, i_fold_id, i_data  - input beat
//          o_valid/i_ready, o_nb_cid_x/y/z, o_is_nb, o_fold_err,
//          o_data                                                  - result beat
//          i_clr_cnt, o_nb_cnt, o_non_nb_cnt                       - counters
module compute_nb_cid_3d_pipe
    import MD_pkg::*;
#(
    parameter int GDIM_X     = 4,
    parameter int GDIM_Y     = 4,
    parameter int GDIM_Z     = 4,
    parameter int NUM_FOLDS  = NUM_CELL_FOLDS,
    parameter logic [GLOBAL_CELL_ID_WIDTH-1:0] HOME_X [NUM_FOLDS] = '{default: '0},
    parameter logic [GLOBAL_CELL_ID_WIDTH-1:0] HOME_Y [NUM_FOLDS] = '{default: '0},
    parameter logic [GLOBAL_CELL_ID_WIDTH-1:0] HOME_Z [NUM_FOLDS] = '{default: '0},
    parameter int DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_valid,
    output logic                            o_ready,
    input  logic [GLOBAL_CELL_ID_WIDTH-1:0] i_src_gcid_x,
    input  logic [GLOBAL_CELL_ID_WIDTH-1:0] i_src_gcid_y,
    input  logic [GLOBAL_CELL_ID_WIDTH-1:0] i_src_gcid_z,
    input  logic [CELL_FOLD_ID_WIDTH-1:0]   i_fold_id,
    input  logic [DATA_WIDTH-1:0]           i_data,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic [CELL_ID_WIDTH-1:0]        o_nb_cid_x,
    output logic [CELL_ID_WIDTH-1:0]        o_nb_cid_y,
    output logic [CELL_ID_WIDTH-1:0]        o_nb_cid_z,
    output logic                            o_is_nb,
    output logic                            o_fold_err,
    output logic [DATA_WIDTH-1:0]           o_data,
    input  logic                            i_clr_cnt,
    output logic [15:0]                     o_nb_cnt,
    output logic [15:0]                     o_non_nb_cnt
);

    localparam logic [GLOBAL_CELL_ID_WIDTH-1:0] GX = GLOBAL_CELL_ID_WIDTH'(GDIM_X);
    localparam logic [GLOBAL_CELL_ID_WIDTH-1:0] GY = GLOBAL_CELL_ID_WIDTH'(GDIM_Y);
    localparam logic [GLOBAL_CELL_ID_WIDTH-1:0] GZ = GLOBAL_CELL_ID_WIDTH'(GDIM_Z);

    // Both stages share one advance enable: the whole pipe moves or holds together.
    logic en;
    logic xfer;

    assign en      = !o_valid || i_ready;
    assign o_ready = en;
    assign xfer    = o_valid && i_ready;

    // ---------------- fold lookup ----------------
    logic [GLOBAL_CELL_ID_WIDTH-1:0] sel_home_x;
    logic [GLOBAL_CELL_ID_WIDTH-1:0] sel_home_y;
    logic [GLOBAL_CELL_ID_WIDTH-1:0] sel_home_z;
    logic                            fold_ok;

    // A loop match instead of direct indexing keeps an out-of-range fold id
    // from reading past the home tables; no match means a fold error.
    always_comb begin
        sel_home_x = '0;
        sel_home_y = '0;
        sel_home_z = '0;
        fold_ok    = 1'b0;
        for (int f = 0; f < NUM_FOLDS; f++) begin
            if (i_fold_id == CELL_FOLD_ID_WIDTH'(f)) begin
                sel_home_x = HOME_X[f];
                sel_home_y = HOME_Y[f];
                sel_home_z = HOME_Z[f];
                fold_ok    = 1'b1;
            end
        end
    end

    // ---------------- stage 1: inputs + selected home ----------------
    logic                            s1_valid;
    logic [GLOBAL_CELL_ID_WIDTH-1:0] s1_src_x;
    logic [GLOBAL_CELL_ID_WIDTH-1:0] s1_src_y;
    logic [GLOBAL_CELL_ID_WIDTH-1:0] s1_src_z;
    logic [GLOBAL_CELL_ID_WIDTH-1:0] s1_home_x;
    logic [GLOBAL_CELL_ID_WIDTH-1:0] s1_home_y;
    logic [GLOBAL_CELL_ID_WIDTH-1:0] s1_home_z;
    logic                            s1_fold_err;
    logic [DATA_WIDTH-1:0]           s1_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_src_x    <= '0;
            s1_src_y    <= '0;
            s1_src_z    <= '0;
            s1_home_x   <= '0;
            s1_home_y   <= '0;
            s1_home_z   <= '0;
            s1_fold_err <= 1'b0;
            s1_data     <= '0;
        end else if (en) begin
            s1_valid    <= i_valid;
            s1_src_x    <= i_src_gcid_x;
            s1_src_y    <= i_src_gcid_y;
            s1_src_z    <= i_src_gcid_z;
            s1_home_x   <= sel_home_x;
            s1_home_y   <= sel_home_y;
            s1_home_z   <= sel_home_z;
            s1_fold_err <= !fold_ok;
            s1_data     <= i_data;
        end
    end

    // ---------------- stage 2: codes ----------------
    nb_code_t code_x;
    nb_code_t code_y;
    nb_code_t code_z;
    logic     is_nb;

    nb_code_1d u_nb_x (.src(s1_src_x), .home(s1_home_x), .gdim(GX), .code(code_x));
    nb_code_1d u_nb_y (.src(s1_src_y), .home(s1_home_y), .gdim(GY), .code(code_y));
    nb_code_1d u_nb_z (.src(s1_src_z), .home(s1_home_z), .gdim(GZ), .code(code_z));

    assign is_nb = !s1_fold_err && (code_x != NB_NONE) && (code_y != NB_NONE)
                   && (code_z != NB_NONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid    <= 1'b0;
            o_nb_cid_x <= '0;
            o_nb_cid_y <= '0;
            o_nb_cid_z <= '0;
            o_is_nb    <= 1'b0;
            o_fold_err <= 1'b0;
            o_data     <= '0;
        end else if (en) begin
            o_valid    <= s1_valid;
            o_nb_cid_x <= s1_fold_err ? NB_NONE : code_x;
            o_nb_cid_y <= s1_fold_err ? NB_NONE : code_y;
            o_nb_cid_z <= s1_fold_err ? NB_NONE : code_z;
            o_is_nb    <= is_nb;
            o_fold_err <= s1_fold_err;
            o_data     <= s1_data;
        end
    end

    // ---------------- event counters ----------------
    // Clear takes priority over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_nb_cnt     <= '0;
            o_non_nb_cnt <= '0;
        end else if (i_clr_cnt) begin
            o_nb_cnt     <= '0;
            o_non_nb_cnt <= '0;
        end else if (xfer) begin
            if (o_is_nb) begin
                if (o_nb_cnt != 16'hFFFF) o_nb_cnt <= o_nb_cnt + 16'd1;
            end else begin
                if (o_non_nb_cnt != 16'hFFFF) o_non_nb_cnt <= o_non_nb_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_compute_nb_cid_3d_pipe.sv
// tb/tb_compute_nb_cid_3d_pipe.sv - self-checking scoreboard bench for compute_nb_cid_3d_pipe
module tb_compute_nb_cid_3d_pipe;
    import MD_pkg::*;

    localparam int NF = 2;
    localparam int G  = 4;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [3:0]  i_src_gcid_x, i_src_gcid_y, i_src_gcid_z;
    logic [1:0]  i_fold_id;
    logic [31:0] i_data;
    logic        o_valid;
    logic        i_ready;
    logic [1:0]  o_nb_cid_x, o_nb_cid_y, o_nb_cid_z;
    logic        o_is_nb;
    logic        o_fold_err;
    logic [31:0] o_data;
    logic        i_clr_cnt;
    logic [15:0] o_nb_cnt, o_non_nb_cnt;

    compute_nb_cid_3d_pipe #(
        .GDIM_X(G), .GDIM_Y(G), .GDIM_Z(G), .NUM_FOLDS(NF),
        .HOME_X('{4'd1, 4'd0}), .HOME_Y('{4'd1, 4'd0}), .HOME_Z('{4'd1, 4'd3}),
        .DATA_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_src_gcid_x(i_src_gcid_x), .i_src_gcid_y(i_src_gcid_y), .i_src_gcid_z(i_src_gcid_z),
        .i_fold_id(i_fold_id), .i_data(i_data), .o_valid(o_valid), .i_ready(i_ready),
        .o_nb_cid_x(o_nb_cid_x), .o_nb_cid_y(o_nb_cid_y), .o_nb_cid_z(o_nb_cid_z),
        .o_is_nb(o_is_nb), .o_fold_err(o_fold_err), .o_data(o_data),
        .i_clr_cnt(i_clr_cnt), .o_nb_cnt(o_nb_cnt), .o_non_nb_cnt(o_non_nb_cnt)
    );

    int hx[NF] = '{1, 0};
    int hy[NF] = '{1, 0};
    int hz[NF] = '{1, 3};

    int vectors    = 0;
    int miscompares = 0;

    logic [63:0] sb[$];
    logic [63:0] outv;
    logic [63:0] held;
    bit          held_v = 0;
    int          m_nb = 0;
    int          m_non = 0;

    assign outv = {23'b0, o_valid, o_nb_cid_x, o_nb_cid_y, o_nb_cid_z, o_is_nb, o_fold_err, o_data};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Ring-distance formulation of the neighbour code.
    function automatic logic [1:0] ref_code(input int src, input int home, input int g);
        int d;
        if (src >= g) return 2'b00;
        d = (src - home + g) % g;
        if (d == 0) return 2'b10;
        if (d == 1) return 2'b11;
        if (d == g - 1) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [63:0] expect_beat(input int f, input int sx, input int sy,
                                                input int sz, input logic [31:0] d);
        logic [1:0] cx, cy, cz;
        logic nb, fe;
        if (f >= NF) begin
            cx = 2'b00; cy = 2'b00; cz = 2'b00; nb = 1'b0; fe = 1'b1;
        end else begin
            cx = ref_code(sx, hx[f], G);
            cy = ref_code(sy, hy[f], G);
            cz = ref_code(sz, hz[f], G);
            nb = (cx != 2'b00) && (cy != 2'b00) && (cz != 2'b00);
            fe = 1'b0;
        end
        return {23'b0, 1'b1, cx, cy, cz, nb, fe, d};
    endfunction

    // Scoreboard monitor: samples on the falling edge.
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst) begin
            m_nb = 0;
            m_non = 0;
            sb.delete();
            held_v = 0;
        end
        chk("nb_cnt", {48'b0, o_nb_cnt}, 64'(m_nb));
        chk("non_nb_cnt", {48'b0, o_non_nb_cnt}, 64'(m_non));
        if (!rst) begin
            if (held_v) chk("stall_hold", outv, held);
            if (o_valid && !i_ready) begin
                chk("o_ready_stall", {63'b0, o_ready}, 64'd0);
                held = outv;
                held_v = 1;
            end else begin
                held_v = 0;
            end
            if (o_valid && i_ready) begin
                vectors++;
                assert (sb.size() != 0) else begin
                    miscompares++;
                    $error("FAIL sb_underflow observed=%0h expected=empty_queue_not_allowed", outv);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("beat", outv, e);
                    if (!i_clr_cnt) begin
                        if (e[33]) m_nb = (m_nb < 65535) ? m_nb + 1 : 65535;
                        else       m_non = (m_non < 65535) ? m_non + 1 : 65535;
                    end
                end
            end
            if (i_clr_cnt) begin
                m_nb = 0;
                m_non = 0;
            end
            if (i_valid && o_ready)
                sb.push_back(expect_beat(int'(i_fold_id), int'(i_src_gcid_x), int'(i_src_gcid_y),
                                         int'(i_src_gcid_z), i_data));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int f, input int sx, input int sy, input int sz, input logic [31:0] d);
        i_fold_id    = 2'(f);
        i_src_gcid_x = 4'(sx);
        i_src_gcid_y = 4'(sy);
        i_src_gcid_z = 4'(sz);
        i_data       = d;
        i_valid      = 1'b1;
    endtask

    int bf[5], bx[5], by[5], bz[5];

    initial begin
        int idx, del, cyc, stall;
        bit seen;

        rst = 1'b1; i_valid = 0; i_ready = 1; i_clr_cnt = 0;
        i_fold_id = 0; i_src_gcid_x = 0; i_src_gcid_y = 0; i_src_gcid_z = 0; i_data = 0;
        step(); step();
        chk("rst_o_ready", {63'b0, o_ready}, 64'd1);
        chk("rst_outputs", outv, 64'd0);
        chk("rst_cnts", {32'b0, o_nb_cnt, o_non_nb_cnt}, 64'd0);
        rst = 1'b0;
        step();

        // Basic neighbour, latency 2
        drive(0, 2, 1, 0, 32'hA000_0001);
        step(); i_valid = 0;
        chk("lat_c1_valid", {63'b0, o_valid}, 64'd0);
        step();
        chk("lat_c2_valid", {63'b0, o_valid}, 64'd1);
        chk("basic_codes", {58'b0, o_nb_cid_x, o_nb_cid_y, o_nb_cid_z}, 64'b11_10_01);
        chk("basic_is_nb", {63'b0, o_is_nb}, 64'd1);
        step();
        chk("basic_nb_cnt", {48'b0, o_nb_cnt}, 64'd1);

        // Wrap-around on fold 1
        drive(1, 3, 1, 0, 32'hA000_0002);
        step(); i_valid = 0;
        step();
        chk("wrap_codes", {58'b0, o_nb_cid_x, o_nb_cid_y, o_nb_cid_z}, 64'b01_11_11);
        chk("wrap_is_nb", {63'b0, o_is_nb}, 64'd1);
        step();

        // Non-neighbour
        drive(0, 3, 1, 1, 32'hA000_0003);
        step(); i_valid = 0;
        step();
        chk("nonnb_x", {62'b0, o_nb_cid_x}, 64'd0);
        chk("nonnb_is_nb", {63'b0, o_is_nb}, 64'd0);
        step();
        chk("nonnb_cnts", {32'b0, o_nb_cnt, o_non_nb_cnt}, {32'b0, 16'd2, 16'd1});

        // Backpressure: 5 back-to-back beats, 3-cycle stall after first o_valid
        for (int k = 0; k < 5; k++) begin
            bf[k] = $urandom_range(0, 1);
            bx[k] = $urandom_range(0, 3);
            by[k] = $urandom_range(0, 3);
            bz[k] = $urandom_range(0, 3);
        end
        idx = 0; del = 0; cyc = 0; stall = 0; seen = 0;
        while (del < 5 && cyc < 60) begin
            if (o_valid && !seen) begin seen = 1; stall = 3; end
            i_ready = (stall == 0);
            if (stall > 0) stall--;
            if (idx < 5) drive(bf[idx], bx[idx], by[idx], bz[idx], 32'hB000_0000 + 32'(idx));
            else i_valid = 0;
            @(negedge clk);
            if (!i_ready) chk("bp_o_ready_low", {63'b0, o_ready}, 64'd0);
            if (i_valid && o_ready) idx++;
            if (o_valid && i_ready) del++;
            step();
            cyc++;
        end
        chk("bp_delivered", 64'(del), 64'd5);
        i_valid = 0; i_ready = 1;
        repeat (3) step();

        // Fold out of range
        drive(NF, 1, 1, 1, 32'hC000_0001);
        step(); i_valid = 0;
        step();
        chk("fold_err_flag", {63'b0, o_fold_err}, 64'd1);
        chk("fold_err_codes", {57'b0, o_nb_cid_x, o_nb_cid_y, o_nb_cid_z, o_is_nb}, 64'd0);
        step();

        // Saturate the neighbour counter
        drive(0, 1, 1, 1, 32'hD000_0000);
        for (int k = 0; k < 65540; k++) begin
            i_data = 32'hD000_0000 + 32'(k);
            step();
        end
        i_valid = 0;
        repeat (3) step();
        chk("sat_nb_cnt", {48'b0, o_nb_cnt}, 64'h0000_0000_0000_FFFF);
        drive(0, 2, 2, 2, 32'hD100_0000);
        step(); i_valid = 0;
        repeat (3) step();
        chk("sat_hold", {48'b0, o_nb_cnt}, 64'h0000_0000_0000_FFFF);

        // Clear coincident with an increment
        drive(0, 1, 1, 1, 32'hE000_0001);
        step(); i_valid = 0;
        step();
        chk("clr_pre_valid", {63'b0, o_valid}, 64'd1);
        i_clr_cnt = 1;
        step();
        i_clr_cnt = 0;
        chk("clr_wins", {32'b0, o_nb_cnt, o_non_nb_cnt}, 64'd0);

        // Reset with two beats in flight
        drive(0, 0, 0, 0, 32'hF000_0001);
        step();
        drive(1, 1, 1, 1, 32'hF000_0002);
        step();
        i_valid = 0; i_ready = 0;
        rst = 1;
        #1;
        chk("rst_mid_valid", {63'b0, o_valid}, 64'd0);
        chk("rst_mid_ready", {63'b0, o_ready}, 64'd1);
        step(); step();
        rst = 0; i_ready = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("no_stale", {63'b0, o_valid}, 64'd0);
        end
        drive(0, 2, 0, 1, 32'hF000_0003);
        step(); i_valid = 0;
        chk("post_rst_c1", {63'b0, o_valid}, 64'd0);
        step();
        chk("post_rst_c2", {31'b0, o_valid, o_data}, {31'b0, 1'b1, 32'hF000_0003});
        repeat (3) step();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/compute_nb_cid_3d_pipe.md
COMPUTE_NB_CID_3D_PIPE -- requirements
Module: compute_nb_cid_3d_pipe

Interface
REQ-001 Parameter GDIM_X, default 4: global cell count along X; legal range >=2.
REQ-002 Parameter GDIM_Y, default 4: global cell count along Y; legal range >=2.
REQ-003 Parameter GDIM_Z, default 4: global cell count along Z; legal range >=2.
REQ-004 Parameter NUM_FOLDS, default NUM_CELL_FOLDS: number of home cells per node.
REQ-005 Parameters HOME_X/HOME_Y/HOME_Z: GLOBAL_CELL_ID_WIDTH-bit arrays of length NUM_FOLDS, default all 0; give the home gcid per fold.
REQ-006 Parameter DATA_WIDTH, default 32: width of the opaque payload that passes through.
REQ-007 clk  in  1  clock; one clock domain.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 i_valid  in  1  input beat valid.
REQ-010 o_ready  out  1  block accepts the input beat.
REQ-011 i_src_gcid_x/y/z  in  GLOBAL_CELL_ID_WIDTH each  source global cell id.
REQ-012 i_fold_id  in  CELL_FOLD_ID_WIDTH  selects the home cell.
REQ-013 i_data  in  DATA_WIDTH  payload.
REQ-014 o_valid  out  1  result valid.
REQ-015 i_ready  in  1  downstream accepts the result.
REQ-016 o_nb_cid_x/y/z  out  CELL_ID_WIDTH each  per-dimension neighbour code.
REQ-017 o_is_nb  out  1  set when all three codes are non-zero.
REQ-018 o_fold_err  out  1  set when i_fold_id >= NUM_FOLDS.
REQ-019 o_data  out  DATA_WIDTH  payload, aligned with the result.
REQ-020 i_clr_cnt  in  1  synchronous clear of the counters.
REQ-021 o_nb_cnt, o_non_nb_cnt  out  16 each  saturating event counters.

Function
REQ-022 Per-dimension code, with G = GDIM and H = the home id:
- source == H -> 2'b10
- source == (H+1) mod G -> 2'b11
- source == (H-1+G) mod G -> 2'b01
- otherwise -> 2'b00 (not a neighbour)
REQ-023 When G==2, so that +1 and -1 alias, the code SHALL be 2'b11.
REQ-024 Wrap-around SHALL be computed without overflow. The -1 case SHALL use H==0 ? G-1 : H-1, and the +1 case SHALL use H==G-1 ? 0 : H+1.
REQ-025 A source id >= G SHALL yield code 2'b00 for that dimension.
REQ-026 The pipeline SHALL have two stages, with latency exactly 2 cycles from an accepted input to o_valid when there is no stall.
REQ-027 Stage 1 SHALL register the inputs together with the fold-selected home ids HOME_*[i_fold_id].
REQ-028 Stage 2 SHALL register the codes, o_is_nb, o_fold_err and o_data.
REQ-029 Advance enable: en = !o_valid | i_ready; o_ready = en (combinational).
REQ-030 Each stage SHALL have its own valid bit, and bubbles SHALL propagate.
REQ-031 While en=0, all stage registers SHALL hold their values and o_* SHALL remain stable.
REQ-032 A transfer occurs on i_valid & o_ready at the input, and on o_valid & i_ready at the output.
REQ-033 When i_fold_id >= NUM_FOLDS: codes = 2'b00, o_is_nb = 0, o_fold_err = 1, and the beat SHALL still be delivered.
REQ-034 Counters SHALL update only on an output transfer:
- o_nb_cnt += 1 when o_is_nb = 1
- otherwise o_non_nb_cnt += 1
REQ-035 Both counters SHALL saturate at 16'hFFFF.
REQ-036 When i_clr_cnt and an increment fall in the same cycle, the clear SHALL win and the counter SHALL read 0 on the next cycle.
REQ-037 Data SHALL never be lost or duplicated under any i_valid/i_ready pattern.

Reset
REQ-038 On rst=1, asynchronously: all stage valid bits = 0, o_valid = 0, o_nb_cid_* = 2'b00, o_is_nb = 0, o_fold_err = 0, o_data = 0, both counters = 0.
REQ-039 While rst=1, o_ready SHALL read 1.
REQ-040 Rst asserted mid-operation SHALL discard all in-flight beats.
REQ-041 After release, the first accepted beat SHALL appear 2 cycles later.

Structure
REQ-042 MD_pkg SHALL hold GLOBAL_CELL_ID_WIDTH, CELL_ID_WIDTH, CELL_FOLD_ID_WIDTH and an nb_code_t enum: NB_NONE=00, NB_MINUS=01, NB_HOME=10, NB_PLUS=11.
REQ-043 One combinational sub-module nb_code_1d (ports: src id, home id, G) SHALL be instantiated three times, once per dimension, in stage 2.

Verification
REQ-044 Directed scenarios:
- GDIM=4, home (1,1,1), fold 0, src (2,1,0), i_ready=1 -> 2 cycles later: codes (11,10,01), o_is_nb=1, o_nb_cnt=1.
- Wrap: home (0,0,3), src (3,1,0) -> codes (01,11,11), o_is_nb=1.
- Non-neighbour: home (1,1,1), src (3,1,1) -> X code 00, o_is_nb=0, o_non_nb_cnt increments.
- Backpressure: 5 back-to-back beats, i_ready held low 3 cycles after the first o_valid -> o_ready=0 while stalled, outputs stable, all 5 beats delivered in order with correct o_data.
- i_fold_id=NUM_FOLDS -> o_fold_err=1, codes 00. A counter preloaded to FFFF stays at FFFF on increment. i_clr_cnt together with an increment -> counter reads 0.
- rst pulsed with 2 beats in flight -> o_valid=0 immediately, no stale beat emitted after release.
